mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-port, 1-cycle-latency unified RAM between instruction fetch and the data access issued by the Execute stage (LW/SW byte-enable pulses). Data accesses are single-cycle pulses that are never held, so the block captures any it cannot issue immediately in a one-entry pending buffer and raises a stall. It tracks the owner of each in-flight read and routes the returned word to fetch or to the MEM stage.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive cycles fetch may lose to data before it is forced through (used only with MEM_ARB_STARVE_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch word address
- if_gnt  out  1  fetch issued to RAM this cycle (combinational)
- if_rdata_vld  out  1  fetch data valid
- if_rdata  out  32  fetch data
- dm_addr  in  32  data address from Execute
- dm_rden  in  4  byte read enables, one-cycle pulse
- dm_wren  in  4  byte write enables, one-cycle pulse
- dm_wrdata  in  32  write data
- dm_busy  out  1  pending buffer occupied; upstream stalls, issues no new data op
- dm_rdata_vld  out  1  load data valid
- dm_rdata  out  32  load data
- dm_ovf  out  1  sticky: data op dropped (protocol violation)
- ram_addr  out  32  RAM address (combinational)
- ram_rden  out  4  RAM byte read enables
- ram_wren  out  4  RAM byte write enables
- ram_wrdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the read is presented

## Operation
- New data op: |dm_rden or |dm_wren. Both nonzero: write wins, dm_rden ignored.
- Per cycle exactly one RAM op, selection order: (1) pending entry; (2) new data op; (3) fetch if if_req. Unselected new data op is written to pending if empty.
- Pending full and a new data op arrives: op dropped, dm_ovf set until rst.
- Pending entry and new data op in the same cycle: pending issues, new op is captured into pending (slot freed that edge).
- FSM (records op issued this cycle, sampled at edge): S_IDLE, S_IF, S_DR, S_DW. Next state from selection; no op -> S_IDLE.
- Response: state S_IF -> if_rdata_vld=1, if_rdata=ram_rdata; S_DR -> dm_rdata_vld=1, dm_rdata=ram_rdata; otherwise both vld 0, data 0.
- dm_busy is the registered pending-valid flag.
- Idle RAM outputs: ram_rden=ram_wren=0, ram_addr/ram_wrdata=0.

## Timing
- Reset: state S_IDLE, pending empty, starvation counter 0; dm_busy, dm_ovf, if_rdata_vld, dm_rdata_vld = 0; if_rdata, dm_rdata = 0; if_gnt 0 and ram_* 0 while rst high.
- Issue latency 0 (combinational ram_* and if_gnt); read data 1 cycle after issue.
- Data op deferred k cycles appears on RAM k cycles late; dm_busy high from cycle after capture through the issue cycle, low the next cycle (unless recaptured).
- Reset mid-read: response discarded, no vld pulse after rst deasserts.
- Back-to-back reads alternate owners freely; each response attributed by the state of its own issue cycle.

## Configuration
- MEM_ARB_STARVE_EN defined: saturating counter increments each cycle if_req is high and not granted, clears on if_gnt. When counter == STARVE_MAX, fetch takes priority over pending and new data op that cycle; new data op goes to pending (or dm_ovf if full).
- Not defined: strict data priority, no counter; fetch can starve indefinitely.

## Test plan
- Lone fetch: if_req=1, if_addr=0x100, RAM[0x100]=0x00500093 -> if_gnt same cycle, next cycle if_rdata_vld=1, if_rdata=0x00500093.
- Collision: if_req=1 and dm_rden=4'hF, dm_addr=0x2000 same cycle -> RAM read 0x2000, dm_rdata_vld next cycle; fetch granted next cycle, if_rdata_vld one cycle after.
- Store: dm_wren=4'hF, dm_addr=0x2004, dm_wrdata=0xDEADBEEF -> ram_wren=4'hF same cycle; later load of 0x2004 returns 0xDEADBEEF; rden+wren together -> write only.
- Overflow: force starvation grant so op A pends, then op B with dm_busy=1, op C next -> dm_ovf=1 held; dropped op never reaches RAM.
- Starvation (MEM_ARB_STARVE_EN, STARVE_MAX=4): if_req held, data op every cycle -> if_gnt on 5th cycle, that data op issues next cycle; without macro if_gnt stays 0.
- Reset during S_DR: assert rst in response cycle -> no dm_rdata_vld, all outputs 0, dm_ovf cleared.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and Execute-stage data accesses
// Optional fetch anti-starvation counter is enabled by defining MEM_ARB_STARVE_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rdata_vld,
    output logic [31:0] if_rdata,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_rden,
    input  logic [3:0]  dm_wren,
    input  logic [31:0] dm_wrdata,
    output logic        dm_busy,
    output logic        dm_rdata_vld,
    output logic [31:0] dm_rdata,
    output logic        dm_ovf,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_rden,
    output logic [3:0]  ram_wren,
    output logic [31:0] ram_wrdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_IF, S_DR, S_DW} state_t;

    state_t      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [3:0]  pend_be_q, pend_be_d;
    logic [31:0] pend_wdata_q, pend_wdata_d;
    logic        ovf_q, ovf_d;

    logic        new_wr, new_vld;
    logic [3:0]  new_be;
    logic        starve_force;
    logic        sel_if, sel_pend, sel_new;

    // A write masks any simultaneous read enables.
    assign new_wr  = |dm_wren;
    assign new_vld = new_wr | (|dm_rden);
    assign new_be  = new_wr ? dm_wren : dm_rden;

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = if_req && (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (sel_if) begin
            starve_cnt_d = '0;
        end else if (if_req && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        sel_if   = 1'b0;
        sel_pend = 1'b0;
        sel_new  = 1'b0;
        if (!rst) begin
            if (starve_force) begin
                sel_if = 1'b1;
            end else if (pend_vld_q) begin
                sel_pend = 1'b1;
            end else if (new_vld) begin
                sel_new = 1'b1;
            end else if (if_req) begin
                sel_if = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr   = '0;
        ram_rden   = '0;
        ram_wren   = '0;
        ram_wrdata = '0;
        state_d    = S_IDLE;
        if (sel_if) begin
            ram_addr = if_addr;
            ram_rden = 4'hF;
            state_d  = S_IF;
        end else if (sel_pend) begin
            ram_addr = pend_addr_q;
            if (pend_wr_q) begin
                ram_wren   = pend_be_q;
                ram_wrdata = pend_wdata_q;
                state_d    = S_DW;
            end else begin
                ram_rden = pend_be_q;
                state_d  = S_DR;
            end
        end else if (sel_new) begin
            ram_addr = dm_addr;
            if (new_wr) begin
                ram_wren   = dm_wren;
                ram_wrdata = dm_wrdata;
                state_d    = S_DW;
            end else begin
                ram_rden = dm_rden;
                state_d  = S_DR;
            end
        end
    end

    // The slot freed by issuing the pending entry can take a new op in the same edge.
    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_be_d    = pend_be_q;
        pend_wdata_d = pend_wdata_q;
        ovf_d        = ovf_q;
        if (sel_pend) begin
            pend_vld_d = 1'b0;
        end
        if (new_vld && !sel_new) begin
            if (!pend_vld_q || sel_pend) begin
                pend_vld_d   = 1'b1;
                pend_wr_d    = new_wr;
                pend_addr_d  = dm_addr;
                pend_be_d    = new_be;
                pend_wdata_d = dm_wrdata;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_vld_q   <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_vld_q   <= pend_vld_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_be_q    <= pend_be_d;
            pend_wdata_q <= pend_wdata_d;
            ovf_q        <= ovf_d;
        end
    end

    assign if_gnt       = sel_if;
    assign dm_busy      = pend_vld_q;
    assign dm_ovf       = ovf_q;
    assign if_rdata_vld = (state_q == S_IF);
    assign if_rdata     = (state_q == S_IF) ? ram_rdata : 32'h0;
    assign dm_rdata_vld = (state_q == S_DR);
    assign dm_rdata     = (state_q == S_DR) ? ram_rdata : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_ARB_STARVE_EN aware)
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam logic [31:0] DROP_ADDR = 32'h0000BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rdata_vld, dm_busy, dm_rdata_vld, dm_ovf;
    logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wrdata;
    logic [31:0] dm_addr = '0;
    logic [3:0]  dm_rden = '0;
    logic [3:0]  dm_wren = '0;
    logic [31:0] dm_wrdata = '0;
    logic [3:0]  ram_rden, ram_wren;
    logic [31:0] ram_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata_vld(if_rdata_vld), .if_rdata(if_rdata),
        .dm_addr(dm_addr), .dm_rden(dm_rden), .dm_wren(dm_wren), .dm_wrdata(dm_wrdata),
        .dm_busy(dm_busy), .dm_rdata_vld(dm_rdata_vld), .dm_rdata(dm_rdata), .dm_ovf(dm_ovf),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_wrdata(ram_wrdata), .ram_rdata(ram_rdata)
    );

    logic [31:0] mem [0:65535];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (|ram_rden) ram_rdata <= mem[ram_addr[15:0]];
        if (|ram_wren) mem[ram_addr[15:0]] <= merge(mem[ram_addr[15:0]], ram_wrdata, ram_wren);
    end

    typedef struct { logic is_if; logic [31:0] data; } resp_t;
    resp_t exp_q[$];

    typedef struct {
        logic rq; logic [31:0] ia, da; logic [3:0] rd, wr; logic [31:0] wd;
        logic gnt; logic [31:0] ea; logic [3:0] erd, ewr; logic [31:0] ewd;
    } vec_t;
    vec_t vt[8];

    int n_chk = 0;
    int n_fail = 0;
    bit drop_seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rq, input logic [31:0] ia, input logic [31:0] da,
                         input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if_req = rq; if_addr = ia; dm_addr = da; dm_rden = rd; dm_wren = wr; dm_wrdata = wd;
    endtask

    task automatic expect_issue(input string name, input logic gnt, input logic [31:0] a,
                                input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] wd,
                                input bit push);
        resp_t r;
        @(negedge clk);
        chk(name, {if_gnt, ram_addr, ram_rden, ram_wren, ram_wrdata}, {gnt, a, rd, wr, wd});
        if (push && rd != 4'h0) begin
            r.is_if = gnt;
            r.data  = mem[a[15:0]];
            exp_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; if_req = 0; dm_rden = 0; dm_wren = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Response scoreboard: every valid pulse must match the oldest outstanding read.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ram_wren != 4'h0 && ram_addr == DROP_ADDR) drop_seen = 1'b1;
                if (if_rdata_vld || dm_rdata_vld) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL resp_unexpected: got if_vld=%0b dm_vld=%0b, required no response",
                                 if_rdata_vld, dm_rdata_vld);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp", {if_rdata_vld, dm_rdata_vld, if_rdata, dm_rdata},
                            {e.is_if, !e.is_if, e.is_if ? e.data : 32'h0, e.is_if ? 32'h0 : e.data});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0100] = 32'h00500093;
        mem[16'h0104] = 32'h00100113;
        mem[16'h2000] = 32'hCAFEF00D;

        vt[0] = '{1'b1, 32'h100, 32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'h100,  4'hF, 4'h0, 32'h0};
        vt[1] = '{1'b0, 32'h0,   32'h2000, 4'hF, 4'h0, 32'h0,        1'b0, 32'h2000, 4'hF, 4'h0, 32'h0};
        vt[2] = '{1'b0, 32'h0,   32'h2004, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h2004, 4'h0, 4'hF, 32'hDEADBEEF};
        vt[3] = '{1'b0, 32'h0,   32'h2008, 4'hF, 4'h3, 32'h11223344, 1'b0, 32'h2008, 4'h0, 4'h3, 32'h11223344};
        vt[4] = '{1'b0, 32'h0,   32'h0,    4'h0, 4'h0, 32'h0,        1'b0, 32'h0,    4'h0, 4'h0, 32'h0};
        vt[5] = '{1'b0, 32'h0,   32'h2004, 4'h1, 4'h0, 32'h0,        1'b0, 32'h2004, 4'h1, 4'h0, 32'h0};
        vt[6] = '{1'b0, 32'h0,   32'h2008, 4'hF, 4'h0, 32'h0,        1'b0, 32'h2008, 4'hF, 4'h0, 32'h0};
        vt[7] = '{1'b1, 32'h104, 32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'h104,  4'hF, 4'h0, 32'h0};

        // Requests present while reset is held must not reach the RAM.
        if_req = 1'b1; if_addr = 32'h100; dm_rden = 4'hF; dm_addr = 32'h2000;
        repeat (2) @(negedge clk);
        chk("rst_gate", {if_gnt, ram_addr, ram_rden, ram_wren, ram_wrdata}, '0);
        chk("rst_outs", {dm_busy, dm_ovf, if_rdata_vld, dm_rdata_vld, if_rdata, dm_rdata}, '0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {if_gnt, ram_rden, ram_wren, dm_busy, dm_ovf, if_rdata_vld, dm_rdata_vld}, '0);

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rq, vt[i].ia, vt[i].da, vt[i].rd, vt[i].wr, vt[i].wd);
            expect_issue($sformatf("vec%0d", i), vt[i].gnt, vt[i].ea, vt[i].erd, vt[i].ewr, vt[i].ewd, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        expect_issue("vec_idle", 0, 0, 0, 0, 0, 1);
        chk("store_load_word", mem[16'h2004], 32'hDEADBEEF);
        chk("rw_both_write_only", mem[16'h2008], 32'h00003344);

        // Collision: data wins, fetch follows the next cycle.
        drive(1, 32'h100, 32'h2000, 4'hF, 4'h0, 0);
        expect_issue("coll_data", 0, 32'h2000, 4'hF, 4'h0, 0, 1);
        drive(1, 32'h100, 0, 0, 0, 0);
        expect_issue("coll_fetch", 1, 32'h100, 4'hF, 4'h0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        expect_issue("coll_idle", 0, 0, 0, 0, 0, 1);

        // Starvation: fetch held against a data read every cycle.
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            a = (c % 2 == 1) ? 32'h2000 : 32'h2004;
            drive(1, 32'h104, a, 4'hF, 4'h0, 0);
`ifdef MEM_ARB_STARVE_EN
            if (c < 5) expect_issue($sformatf("starve_lose%0d", c), 0, a, 4'hF, 4'h0, 0, 1);
            else       expect_issue("starve_forced_gnt", 1, 32'h104, 4'hF, 4'h0, 0, 1);
`else
            expect_issue($sformatf("starve_data%0d", c), 0, a, 4'hF, 4'h0, 0, 1);
`endif
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef MEM_ARB_STARVE_EN
        expect_issue("starve_pend_issue", 0, 32'h2000, 4'hF, 4'h0, 0, 1);
        chk("starve_busy_on_issue", dm_busy, 1'b1);
`else
        expect_issue("nostarve_idle", 0, 0, 0, 0, 0, 1);
        chk("nostarve_busy", dm_busy, 1'b0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        expect_issue("starve_tail_idle", 0, 0, 0, 0, 0, 1);
        chk("starve_busy_clear", dm_busy, 1'b0);

        // Overflow: stores every cycle with fetch held; the 10th store meets a full slot.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            a = (c == 10) ? DROP_ADDR : 32'h3000 + 32'(4 * c);
            drive(1, 32'h104, a, 4'h0, 4'hF, 32'(c));
`ifdef MEM_ARB_STARVE_EN
            if (c <= 4)
                expect_issue($sformatf("ovf_c%0d", c), 0, a, 4'h0, 4'hF, 32'(c), 1);
            else if (c == 5 || c == 10)
                expect_issue($sformatf("ovf_c%0d", c), 1, 32'h104, 4'hF, 4'h0, 0, 1);
            else
                expect_issue($sformatf("ovf_c%0d", c), 0, 32'h3000 + 32'(4 * (c - 1)), 4'h0, 4'hF, 32'(c - 1), 1);
            if (c == 10) chk("ovf_busy_full", {dm_busy, dm_ovf}, 2'b10);
`else
            expect_issue($sformatf("ovf_c%0d", c), 0, a, 4'h0, 4'hF, 32'(c), 1);
`endif
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef MEM_ARB_STARVE_EN
        expect_issue("ovf_last_pend", 0, 32'h3024, 4'h0, 4'hF, 32'd9, 1);
        chk("ovf_set", dm_ovf, 1'b1);
`else
        expect_issue("ovf_none_idle", 0, 0, 0, 0, 0, 1);
        chk("ovf_never", dm_ovf, 1'b0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        expect_issue("ovf_idle", 0, 0, 0, 0, 0, 1);
`ifdef MEM_ARB_STARVE_EN
        chk("ovf_sticky", {dm_ovf, dm_busy}, 2'b10);
        chk("ovf_drop_never_issued", drop_seen, 1'b0);
`else
        chk("ovf_sticky_off", {dm_ovf, dm_busy}, 2'b00);
`endif

        // Reset lands in the response cycle of a data read.
        drive(0, 0, 32'h2000, 4'hF, 4'h0, 0);
        expect_issue("rst_mid_issue", 0, 32'h2000, 4'hF, 4'h0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; dm_rden = 4'hF;
        @(negedge clk);
        chk("rst_mid_outs", {if_gnt, ram_addr, ram_rden, ram_wren, ram_wrdata, dm_busy, dm_ovf,
                             if_rdata_vld, dm_rdata_vld, if_rdata, dm_rdata}, '0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_vld", {if_rdata_vld, dm_rdata_vld, dm_ovf}, 3'b000);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
